// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage load/store unit bridging the pipeline to a req/ack word bus
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   ALU_outM_i, WriteDataM_i    byte address and store data of the memory-stage access
//   Funct3M_i                   access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   MemWriteM_i, MemReadM_i     store / load request (both high counts as store)
//   ReadDataM_o                 registered, formatted load result
//   StallM_o                    pipeline hold request
//   MisalignM_o, BusErrM_o      one-cycle fault pulses
//   mem_req_o .. mem_be_o       registered word-bus request
//   mem_ack_i, mem_rdata_i      bus acknowledge and read data
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALU_outM_i,
  input  logic [31:0] WriteDataM_i,
  input  logic [2:0]  Funct3M_i,
  input  logic        MemWriteM_i,
  input  logic        MemReadM_i,
  output logic [31:0] ReadDataM_o,
  output logic        StallM_o,
  output logic        MisalignM_o,
  output logic        BusErrM_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  // Timeout fires on the BUSY cycle in which the counter would reach 255.
  localparam logic [7:0] WAIT_LAST = 8'd254;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misalign_q, misalign_d;
  logic        buserr_q, buserr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        stall_c;

  logic        access;
  logic        aligned;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_fmt;

  assign access = MemWriteM_i | MemReadM_i;

  // Funct3[1:0] is the size (00 byte, 01 half, else word); funct3[2] marks unsigned loads.
  always_comb begin
    aligned = 1'b1;
    be_c    = 4'b1111;
    wdata_c = WriteDataM_i;
    case (Funct3M_i[1:0])
      2'b00: begin
        be_c    = 4'b0001 << ALU_outM_i[1:0];
        wdata_c = {4{WriteDataM_i[7:0]}};
      end
      2'b01: begin
        aligned = ~ALU_outM_i[0];
        be_c    = 4'b0011 << ALU_outM_i[1:0];
        wdata_c = {2{WriteDataM_i[15:0]}};
      end
      default: begin
        aligned = (ALU_outM_i[1:0] == 2'b00);
      end
    endcase
    // Loads always fetch the whole word; lane selection happens on return.
    if (!MemWriteM_i) begin
      be_c = 4'b1111;
    end
  end

  // Return-path formatting uses the latched offset and funct3 of the access.
  always_comb begin
    case (off_q)
      2'd0:    lane_byte = mem_rdata_i[7:0];
      2'd1:    lane_byte = mem_rdata_i[15:8];
      2'd2:    lane_byte = mem_rdata_i[23:16];
      default: lane_byte = mem_rdata_i[31:24];
    endcase
    lane_half = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (funct3_q[1:0])
      2'b00:   load_fmt = funct3_q[2] ? {24'd0, lane_byte}
                                      : {{24{lane_byte[7]}}, lane_byte};
      2'b01:   load_fmt = funct3_q[2] ? {16'd0, lane_half}
                                      : {{16{lane_half[15]}}, lane_half};
      default: load_fmt = mem_rdata_i;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    funct3_d   = funct3_q;
    off_d      = off_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    misalign_d = 1'b0;
    buserr_d   = 1'b0;
    stall_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (aligned) begin
            stall_c  = 1'b1;
            state_d  = BUSY;
            req_d    = 1'b1;
            we_d     = MemWriteM_i;
            addr_d   = {ALU_outM_i[31:2], 2'b00};
            be_d     = be_c;
            wdata_d  = wdata_c;
            funct3_d = Funct3M_i;
            off_d    = ALU_outM_i[1:0];
            cnt_d    = 8'd0;
          end else begin
            misalign_d = 1'b1;
            rdata_d    = 32'd0;
          end
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (mem_ack_i) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (!we_q) begin
            rdata_d = load_fmt;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == WAIT_LAST) begin
            state_d  = DONE;
            req_d    = 1'b0;
            rdata_d  = 32'd0;
            buserr_d = 1'b1;
          end
        end
      end
      DONE: begin
        // Inputs seen here belong to the stalled instruction; never restart.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      be_q       <= 4'd0;
      funct3_q   <= 3'd0;
      off_q      <= 2'd0;
      rdata_q    <= 32'd0;
      cnt_q      <= 8'd0;
      misalign_q <= 1'b0;
      buserr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      funct3_q   <= funct3_d;
      off_q      <= off_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
      buserr_q   <= buserr_d;
    end
  end

  // The state register may still read BUSY during the first reset cycle.
  assign StallM_o    = stall_c & ~rst;
  assign ReadDataM_o = rdata_q;
  assign MisalignM_o = misalign_q;
  assign BusErrM_o   = buserr_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_be_o    = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic [31:0] addr_i;
  logic [31:0] wd_i;
  logic [2:0]  f3_i;
  logic        we_i;
  logic        re_i;
  logic [31:0] ReadDataM_o;
  logic        StallM_o;
  logic        MisalignM_o;
  logic        BusErrM_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        ack_i;
  logic [31:0] rdata_i;

  load_store_unit dut (
    .clk          (clk),
    .rst          (rst),
    .ALU_outM_i   (addr_i),
    .WriteDataM_i (wd_i),
    .Funct3M_i    (f3_i),
    .MemWriteM_i  (we_i),
    .MemReadM_i   (re_i),
    .ReadDataM_o  (ReadDataM_o),
    .StallM_o     (StallM_o),
    .MisalignM_o  (MisalignM_o),
    .BusErrM_o    (BusErrM_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_be_o     (mem_be_o),
    .mem_ack_i    (ack_i),
    .mem_rdata_i  (rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        re;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          delay;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  logic [31:0] model_rd;
  int          checks;
  int          errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drop_inputs();
    we_i   = 1'b0;
    re_i   = 1'b0;
    f3_i   = 3'd0;
    addr_i = 32'd0;
    wd_i   = 32'd0;
  endtask

  task automatic run_access(input vec_t v);
    int stalls;
    stalls = 0;
    we_i   = v.we;
    re_i   = v.re;
    f3_i   = v.f3;
    addr_i = v.addr;
    wd_i   = v.wd;
    exp_q.push_back(v.we ? model_rd : v.exp_rdata);
    if (!v.we) model_rd = v.exp_rdata;
    #1;
    chk("stall_idle", {31'd0, StallM_o}, 32'd1);
    chk("no_req_idle", {31'd0, mem_req_o}, 32'd0);
    stalls += int'(StallM_o);
    @(posedge clk); #1;
    chk("req_busy", {31'd0, mem_req_o}, 32'd1);
    chk("addr", mem_addr_o, {v.addr[31:2], 2'b00});
    chk("be", {28'd0, mem_be_o}, {28'd0, v.exp_be});
    chk("we", {31'd0, mem_we_o}, {31'd0, v.we});
    if (v.we) chk("wdata", mem_wdata_o, v.exp_wdata);
    for (int i = 0; i < v.delay; i++) begin
      stalls += int'(StallM_o);
      @(posedge clk); #1;
      chk("req_hold", {31'd0, mem_req_o}, 32'd1);
      chk("addr_hold", mem_addr_o, {v.addr[31:2], 2'b00});
    end
    stalls += int'(StallM_o);
    ack_i   = 1'b1;
    rdata_i = v.rdata;
    @(posedge clk); #1;
    ack_i   = 1'b0;
    rdata_i = $urandom;
    chk("req_done", {31'd0, mem_req_o}, 32'd0);
    chk("stall_done", {31'd0, StallM_o}, 32'd0);
    chk("rdata", ReadDataM_o, exp_q.pop_front());
    chk("stall_cycles", stalls, 2 + v.delay);
    // Inputs still held through DONE must not launch a second access.
    @(posedge clk); #1;
    chk("no_restart", {31'd0, mem_req_o}, 32'd0);
    chk("rdata_hold", ReadDataM_o, model_rd);
    drop_inputs();
    @(posedge clk); #1;
  endtask

  task automatic run_misalign(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    we_i   = we;
    re_i   = ~we;
    f3_i   = f3;
    addr_i = addr;
    wd_i   = 32'h5555AAAA;
    #1;
    chk("mis_stall", {31'd0, StallM_o}, 32'd0);
    @(posedge clk); #1;
    drop_inputs();
    model_rd = 32'd0;
    chk("mis_pulse", {31'd0, MisalignM_o}, 32'd1);
    chk("mis_rdata", ReadDataM_o, model_rd);
    chk("mis_noreq", {31'd0, mem_req_o}, 32'd0);
    @(posedge clk); #1;
    chk("mis_one_cycle", {31'd0, MisalignM_o}, 32'd0);
    chk("mis_noreq2", {31'd0, mem_req_o}, 32'd0);
  endtask

  initial begin
    int k;
    checks   = 0;
    errors   = 0;
    model_rd = 32'd0;
    rst      = 1'b1;
    ack_i    = 1'b0;
    rdata_i  = 32'd0;
    drop_inputs();

    //              we    re    f3      addr          wd            rdata         dly be       wdata         rdata
    vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h00000100, 32'h0,        32'hDEADBEEF, 0, 4'b1111, 32'h0,        32'hDEADBEEF});
    vecs.push_back('{1'b0, 1'b1, 3'b000, 32'h00000103, 32'h0,        32'h80112233, 0, 4'b1111, 32'h0,        32'hFFFFFF80});
    vecs.push_back('{1'b0, 1'b1, 3'b100, 32'h00000103, 32'h0,        32'h80112233, 0, 4'b1111, 32'h0,        32'h00000080});
    vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h00000102, 32'h0000ABCD, 32'h0,        0, 4'b1100, 32'hABCDABCD, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h00000102, 32'h0,        32'h80017FFF, 3, 4'b1111, 32'h0,        32'hFFFF8001});
    vecs.push_back('{1'b0, 1'b1, 3'b101, 32'h00000102, 32'h0,        32'h80017FFF, 0, 4'b1111, 32'h0,        32'h00008001});
    vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h00000100, 32'h0,        32'h80017FFF, 1, 4'b1111, 32'h0,        32'h00007FFF});
    vecs.push_back('{1'b1, 1'b0, 3'b000, 32'h00000101, 32'h123456A5, 32'h0,        2, 4'b0010, 32'hA5A5A5A5, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h00000104, 32'hCAFEF00D, 32'h0,        0, 4'b1111, 32'hCAFEF00D, 32'h0});
    vecs.push_back('{1'b1, 1'b1, 3'b010, 32'h00000108, 32'h11223344, 32'h0,        0, 4'b1111, 32'h11223344, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 3'b000, 32'h00000101, 32'h0,        32'h00007F00, 1, 4'b1111, 32'h0,        32'h0000007F});
    vecs.push_back('{1'b0, 1'b1, 3'b000, 32'h00000102, 32'h0,        32'h00FE0000, 0, 4'b1111, 32'h0,        32'hFFFFFFFE});
    vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h00000100, 32'h1234BEEF, 32'h0,        0, 4'b0011, 32'hBEEFBEEF, 32'h0});

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_we", {31'd0, mem_we_o}, 32'd0);
    chk("rst_be", {28'd0, mem_be_o}, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    chk("rst_rdata", ReadDataM_o, 32'd0);
    chk("rst_mis", {31'd0, MisalignM_o}, 32'd0);
    chk("rst_buserr", {31'd0, BusErrM_o}, 32'd0);
    chk("rst_stall", {31'd0, StallM_o}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) run_access(vecs[i]);

    run_misalign(1'b0, 3'b010, 32'h00000101);
    run_access(vecs[0]);
    run_misalign(1'b0, 3'b001, 32'h00000103);
    run_misalign(1'b1, 3'b010, 32'h00000102);
    run_misalign(1'b1, 3'b001, 32'h00000201);

    // Reset in the middle of a BUSY access; a late ack must be ignored.
    run_access(vecs[0]);
    re_i   = 1'b1;
    f3_i   = 3'b010;
    addr_i = 32'h00000300;
    @(posedge clk); #1;
    chk("rb_req", {31'd0, mem_req_o}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    drop_inputs();
    #1;
    chk("rb_stall_in_rst", {31'd0, StallM_o}, 32'd0);
    @(posedge clk); #1;
    chk("rb_req_dropped", {31'd0, mem_req_o}, 32'd0);
    chk("rb_rdata_clr", ReadDataM_o, 32'd0);
    rst     = 1'b0;
    ack_i   = 1'b1;
    rdata_i = 32'hDEADBEEF;
    @(posedge clk); #1;
    ack_i = 1'b0;
    chk("rb_late_ack_req", {31'd0, mem_req_o}, 32'd0);
    chk("rb_late_ack_stall", {31'd0, StallM_o}, 32'd0);
    @(posedge clk); #1;
    chk("rb_no_done", ReadDataM_o, 32'd0);
    model_rd = 32'd0;

    // Ack never returns: bus error after 255 BUSY cycles.
    run_access(vecs[1]);
    re_i   = 1'b1;
    f3_i   = 3'b010;
    addr_i = 32'h00000200;
    @(posedge clk); #1;
    drop_inputs();
    chk("to_req", {31'd0, mem_req_o}, 32'd1);
    k = 0;
    while (!BusErrM_o && k < 300) begin
      chk("to_stall", {31'd0, StallM_o}, 32'd1);
      @(posedge clk); #1;
      k++;
    end
    chk("to_busy_cycles", k, 255);
    chk("to_buserr", {31'd0, BusErrM_o}, 32'd1);
    chk("to_rdata", ReadDataM_o, 32'd0);
    chk("to_req_drop", {31'd0, mem_req_o}, 32'd0);
    chk("to_stall_done", {31'd0, StallM_o}, 32'd0);
    @(posedge clk); #1;
    chk("to_pulse_one", {31'd0, BusErrM_o}, 32'd0);
    chk("to_idle_noreq", {31'd0, mem_req_o}, 32'd0);
    run_access(vecs[2]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
